// File: rtl/vga_mem_viewer.sv
// Purpose: snapshots the first NUM_BYTES bytes of data memory once per frame (in vblank)
//          and draws them as an 8-cell-wide bit grid on a 640x480@60 VGA raster.
// Latency: hsync/vsync/rgb are registered one pixel after hc/vc; rd_data is captured the same clk.
// Backpressure: none; the raster free-runs and the memory read port must answer combinationally.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rd_addr, rd_en      byte read port into data memory (rd_addr is 0 whenever rd_en is 0)
//   rd_data             byte at rd_addr, valid in the same cycle
//   hsync, vsync        active-low sync pulses
//   vga_r/g/b           4-bit colour channels
//   frame_done          1-clk pulse after the last snapshot byte is captured
// The raster timing parameters default to 640x480@60; they exist so the grid logic can be
// exercised on a shrunken raster.
module vga_mem_viewer #(
  parameter int NUM_BYTES    = 21,
  parameter int CLK_DIV      = 2,
  parameter int CELL_LOG2    = 4,
  parameter int GRID_X       = 64,
  parameter int GRID_Y       = 48,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_END);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] GX  = 10'(GRID_X);
  localparam logic [9:0] GY  = 10'(GRID_Y);
  localparam logic [9:0] NB  = 10'(NUM_BYTES);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  // ---------------- pixel enable ----------------
  logic [DIV_W-1:0] div;
  logic             pe;

  assign pe = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)     div <= '0;
    else if (pe) div <= '0;
    else         div <= div + 1'b1;
  end

  // ---------------- raster counters ----------------
  logic [9:0] hc, vc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pe) begin
      if (hc == HT1) begin
        hc <= '0;
        vc <= (vc == VT1) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // ---------------- snapshot / fetch FSM ----------------
  logic [7:0]       snap [NUM_BYTES];
  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             cap;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rd_en      = 1'b0;
    rd_addr    = 32'd0;
    frame_done = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        // First pixel of vertical blanking kicks off the snapshot.
        if (pe && hc == 10'd0 && vc == VA) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = 32'(idx);
        cap     = 1'b1;
        idx_nxt = idx + 1'b1;
        if (idx == IDX_W'(NUM_BYTES - 1)) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < NUM_BYTES; i++) snap[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap) snap[idx] <= rd_data;
    end
  end

  // ---------------- grid geometry and colour ----------------
  logic [9:0]       dx, dy, col, row;
  logic             active, in_grid, lit;
  logic [IDX_W-1:0] row_i;
  logic [11:0]      rgb_nxt;

  always_comb begin
    dx      = hc - GX;
    dy      = vc - GY;
    col     = dx >> CELL_LOG2;
    row     = dy >> CELL_LOG2;
    active  = (hc < HA) && (vc < VA);
    in_grid = (hc >= GX) && (vc >= GY) && (col < 10'd8) && (row < NB);
    row_i   = in_grid ? row[IDX_W-1:0] : '0;
    // bit7 is the leftmost cell, so the bit index is 7-col == ~col[2:0].
    lit     = snap[row_i][~col[2:0]];
    rgb_nxt = 12'h000;
    if (active && in_grid) rgb_nxt = lit ? 12'hFFF : 12'h222;
  end

  // Sync and colour share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
    end else if (pe) begin
      hsync <= !((hc >= HSS) && (hc < HSE));
      vsync <= !((vc >= VSS) && (vc < VSE));
      {vga_r, vga_g, vga_b} <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_vga_mem_viewer.sv
// Purpose: randomized self-checking bench for vga_mem_viewer on a shrunken raster.
// Latency: the model predicts every output after each clk edge from the clk count alone.
// Backpressure: n/a; the memory model answers combinationally.
module tb_vga_mem_viewer;

  localparam int NB   = 21;
  localparam int DIV  = 2;
  localparam int CL2  = 2;
  localparam int GX   = 4;
  localparam int GY   = 2;
  localparam int HA   = 40;
  localparam int HSS  = 42;
  localparam int HSE  = 46;
  localparam int HT   = 48;
  localparam int VA   = 88;
  localparam int VSS  = 90;
  localparam int VSE  = 92;
  localparam int VT   = 94;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        hsync, vsync, frame_done;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic [7:0]  mem [NB];

  always #5 clk = ~clk;

  assign rd_data = (rd_addr < NB) ? mem[rd_addr[4:0]] : 8'h00;

  vga_mem_viewer #(
    .NUM_BYTES(NB), .CLK_DIV(DIV), .CELL_LOG2(CL2), .GRID_X(GX), .GRID_Y(GY),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_done(frame_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: clk edges since reset release, snapshot, last fetch start edge.
  int         n       = 0;
  int         fetch_e = -1;
  int         cur_pi  = -1;
  logic [7:0] ref_snap [NB];
  int         pass    = 0;

  // First-frame statistics, checked against plain arithmetic.
  int cnt_rd_en = 0, cnt_done = 0, cnt_hlow = 0, cnt_vlow = 0, addr_order_bad = 0, next_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int pi);
    int hc, vc, col, row;
    hc = pi % HT;
    vc = (pi / HT) % VT;
    if (hc >= HA || vc >= VA || hc < GX || vc < GY) return 12'h000;
    col = (hc - GX) / (1 << CL2);
    row = (vc - GY) / (1 << CL2);
    if (col >= 8 || row >= NB) return 12'h000;
    return ref_snap[row][7 - col] ? 12'hFFF : 12'h222;
  endfunction

  task automatic model_edge();
    int k;
    if (rst) begin
      n = 0;
      fetch_e = -1;
      for (int i = 0; i < NB; i++) ref_snap[i] = 8'h00;
    end else begin
      n++;
      k = n - fetch_e - 1;
      if (fetch_e >= 0 && k >= 0 && k < NB) ref_snap[k] = mem[k];
      if (n % DIV == 0) begin
        if ((n / DIV - 1) % FRAME == VA * HT) fetch_e = n;
      end
    end
    cur_pi = (n >= DIV) ? n / DIV - 1 : -1;
  endtask

  task automatic check_outputs();
    logic       e_hs, e_vs, e_en, e_fd;
    logic [11:0] e_rgb;
    logic [31:0] e_addr;
    int hc, vc, d;
    e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
    if (cur_pi >= 0) begin
      hc = cur_pi % HT;
      vc = (cur_pi / HT) % VT;
      e_hs  = !(hc >= HSS && hc < HSE);
      e_vs  = !(vc >= VSS && vc < VSE);
      e_rgb = exp_rgb(cur_pi);
    end
    d      = n - fetch_e;
    e_en   = (fetch_e >= 0 && d >= 0 && d < NB);
    e_addr = e_en ? 32'(d) : 32'd0;
    e_fd   = (fetch_e >= 0 && d == NB);
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("rd_en", 32'(rd_en), 32'(e_en));
    chk("rd_addr", rd_addr, e_addr);
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (pass == 0 && cur_pi >= 0 && cur_pi < FRAME) begin
      if (rd_en) begin
        cnt_rd_en++;
        if (rd_addr != 32'(next_addr)) addr_order_bad++;
        next_addr++;
      end
      if (frame_done) cnt_done++;
      if (!hsync) cnt_hlow++;
      if (!vsync) cnt_vlow++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to_pix(input int target);
    int budget;
    budget = 0;
    while (cur_pi < target) begin
      step();
      budget++;
      if (budget > 20 * FRAME * DIV) begin
        n_fail++;
        $display("FAIL run_to_pix timeout: at pixel %0d, wanted %0d", cur_pi, target);
        break;
      end
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    for (int i = 0; i < NB; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5;
    repeat (3) step();
    rst = 1'b0;

    // Frame 1 (snapshot of A5 in its vblank), into frame 2 visible area.
    run_to_pix(FRAME + 20 * HT);
    chk("first_fetch_len", 32'(cnt_rd_en), 32'(NB));
    chk("first_fetch_order", 32'(addr_order_bad), 32'd0);
    chk("first_done_cnt", 32'(cnt_done), 32'd1);
    chk("hsync_low_cycles", 32'(cnt_hlow), 32'(VT * (HSE - HSS) * DIV));
    chk("vsync_low_cycles", 32'(cnt_vlow), 32'(HT * (VSE - VSS) * DIV));

    // CPU clears byte0 mid-frame: row 0 keeps A5 until the next vblank.
    mem[0] = 8'h00;
    run_to_pix(2 * FRAME + 20 * HT);
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);

    // Reset during the fetch while idx=10.
    run_to_pix(2 * FRAME + VA * HT);
    waited = 0;
    while (!(fetch_e >= 0 && n - fetch_e == 10) && waited < 100) begin
      step();
      waited++;
    end
    chk("fetch_reached_idx10", 32'(rd_addr), 32'd10);
    pass = 1;
    rst = 1'b1;
    step();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    rst = 1'b0;

    // After reset: one all-zero frame, then fresh fetch; random CPU writes throughout.
    while (cur_pi < 3 * FRAME + 100) begin
      step();
      if ($urandom_range(0, 199) == 0) mem[$urandom_range(0, NB - 1)] = 8'($urandom);
      if (n > 20 * FRAME * DIV) begin
        n_fail++;
        $display("FAIL final_run timeout: at pixel %0d", cur_pi);
        break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
